srt_div_arbiter: RTL

Round-robin arbiter and sequencer that shares one SRTDivision core among NUM_REQ requesters. It accepts signed divide requests on per-requester valid/ready channels, dispatches one at a time to the divider's start/ready interface, and returns quotient, remainder and requester ID on a single response channel. Divide-by-zero is handled locally, and a hung divider is caught by a watchdog so the shared core can never deadlock its clients.

---
 rtl/srt_div_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/srt_div_arbiter.sv
// Round-robin front end sharing one SRT divider among NUM_REQ requesters.
// Zero divisors are answered locally; a watchdog aborts a divider that never responds.
module srt_div_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic [WIDTH-1:0]         div_remainder,
  input  logic                     div_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_quotient,
  output logic [WIDTH-1:0]         rsp_remainder,
  output logic [1:0]               rsp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             start_q, rsp_valid_q;
  logic [WIDTH-1:0] dvd_q, dvs_q, quo_q, rem_q;
  logic [IDW-1:0]   id_q;
  logic [1:0]       err_q;

  logic             gnt_vld;
  logic [IDW-1:0]   gnt_id;
  logic [IDW:0]     cand;
  logic [WIDTH-1:0] gnt_dvd, gnt_dvs;

  // Search upward from ptr, wrapping at NUM_REQ (not a power of two in general).
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      if (!gnt_vld && req_valid[cand[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand[IDW-1:0];
      end
    end
  end

  assign gnt_dvd = req_dividend[gnt_id*WIDTH +: WIDTH];
  assign gnt_dvs = req_divisor[gnt_id*WIDTH +: WIDTH];
  assign ptr_d   = (gnt_id == IDW'(NUM_REQ-1)) ? '0 : gnt_id + IDW'(1);
  assign cnt_d   = cnt_q + 8'd1;

  always_comb begin
    req_ready = '0;
    if (reset && state_q == IDLE && gnt_vld) req_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rsp_valid_q <= 1'b0;
      id_q        <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      err_q       <= 2'b00;
    end else begin
      case (state_q)
        IDLE: if (gnt_vld) begin
          dvd_q <= gnt_dvd;
          dvs_q <= gnt_dvs;
          id_q  <= gnt_id;
          ptr_q <= ptr_d;
          if (gnt_dvs == '0) begin
            quo_q       <= '1;
            rem_q       <= gnt_dvd;
            err_q       <= 2'b01;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            start_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          start_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_d;
          // cnt_q==0 marks the first WAIT cycle, where div_ready may be left over.
          if (cnt_q != 8'd0 && div_ready) begin
            quo_q       <= div_quotient;
            rem_q       <= div_remainder;
            err_q       <= 2'b00;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_d == 8'(TIMEOUT)) begin
            quo_q       <= '0;
            rem_q       <= '0;
            err_q       <= 2'b10;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div_start     = start_q;
  assign div_dividend  = dvd_q;
  assign div_divisor   = dvs_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = id_q;
  assign rsp_quotient  = quo_q;
  assign rsp_remainder = rem_q;
  assign rsp_err       = err_q;

endmodule
